// File: rtl/coder_4_2_serial_rx_if.sv
// Handshake bundle for the 4-2 serial receiver.
//   code_in / code_valid / code_ready     : one-hot code stream from the coder
//   index_out / index_valid / index_ready : decoded 2-bit index stream to the consumer
// master = code producer + index consumer side, slave = the receiver itself.
interface coder_4_2_serial_rx_if;
  logic [3:0] code_in;
  logic       code_valid;
  logic       code_ready;
  logic [1:0] index_out;
  logic       index_valid;
  logic       index_ready;

  modport master (
    output code_in, code_valid, index_ready,
    input  code_ready, index_out, index_valid
  );

  modport slave (
    input  code_in, code_valid, index_ready,
    output code_ready, index_out, index_valid
  );
endinterface

// File: rtl/coder_4_2_serial_rx.sv
// Receive end of the serial 4-2 coder link.
// Decodes one-hot codes (0001,0010,0100,1000) to a 2-bit index, buffers the
// indices in a DEPTH-entry FIFO, tracks the mod-4 counter sequence with a
// HUNT/LOCK FSM, flags the 3->0 wrap (OV) and counts malformed codes.
// Ports:
//   clk        : rising-edge clock
//   Reset      : asynchronous active-high reset
//   bus        : code / index handshakes (slave side)
//   OV         : 1-cycle pulse, accepted index 0 right after index 3
//   err_onehot : 1-cycle pulse, malformed code accepted
//   err_seq    : 1-cycle pulse, index differs from expected while locked
//   locked     : FSM is in LOCK
//   err_count  : saturating malformed-code counter
module coder_4_2_serial_rx #(
  parameter int DEPTH     = 4,
  parameter int CHECK_SEQ = 1,
  parameter int ERRW      = 8
) (
  input  logic                    clk,
  input  logic                    Reset,
  coder_4_2_serial_rx_if.slave    bus,
  output logic                    OV,
  output logic                    err_onehot,
  output logic                    err_seq,
  output logic                    locked,
  output logic [ERRW-1:0]         err_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {HUNT, LOCK} state_t;

  // FIFO storage and pointers; pointers carry one extra wrap bit so that
  // full and empty are distinguishable without a separate counter.
  logic [1:0]  mem [DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic [1:0]  last_out_reg;

  state_t          state_reg;
  logic [1:0]      exp_idx_reg;
  logic [1:0]      last_idx_reg;
  logic            ov_reg;
  logic            err_onehot_reg;
  logic            err_seq_reg;
  logic [ERRW-1:0] err_count_reg;

  logic       full;
  logic       empty;
  logic       accept;
  logic       pop;
  logic       code_ok;
  logic [1:0] dec_idx;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  assign accept = bus.code_valid & ~full;
  assign pop    = ~empty & bus.index_ready;

  always_comb begin
    code_ok = 1'b1;
    dec_idx = 2'd0;
    case (bus.code_in)
      4'b0001: dec_idx = 2'd0;
      4'b0010: dec_idx = 2'd1;
      4'b0100: dec_idx = 2'd2;
      4'b1000: dec_idx = 2'd3;
      default: code_ok = 1'b0;
    endcase
  end

  // Storage has no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (accept && code_ok) begin
      mem[wr_ptr_reg[AW-1:0]] <= dec_idx;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      last_out_reg <= 2'd0;
    end else begin
      if (accept && code_ok) begin
        wr_ptr_reg <= wr_ptr_reg + {{AW{1'b0}}, 1'b1};
      end
      if (pop) begin
        rd_ptr_reg   <= rd_ptr_reg + {{AW{1'b0}}, 1'b1};
        // Remember the popped value so index_out holds it while empty.
        last_out_reg <= mem[rd_ptr_reg[AW-1:0]];
      end
    end
  end

  // Sequence tracker, wrap detector and error counter.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_reg      <= HUNT;
      exp_idx_reg    <= 2'd0;
      last_idx_reg   <= 2'd0;
      ov_reg         <= 1'b0;
      err_onehot_reg <= 1'b0;
      err_seq_reg    <= 1'b0;
      err_count_reg  <= '0;
    end else begin
      ov_reg         <= 1'b0;
      err_onehot_reg <= 1'b0;
      err_seq_reg    <= 1'b0;
      if (accept) begin
        if (!code_ok) begin
          err_onehot_reg <= 1'b1;
          state_reg      <= HUNT;
          if (err_count_reg != {ERRW{1'b1}}) begin
            err_count_reg <= err_count_reg + {{(ERRW-1){1'b0}}, 1'b1};
          end
        end else begin
          ov_reg       <= (dec_idx == 2'd0) && (last_idx_reg == 2'd3);
          last_idx_reg <= dec_idx;
          // Both states resynchronise the expectation to the received index.
          exp_idx_reg  <= dec_idx + 2'd1;
          case (state_reg)
            HUNT: state_reg <= LOCK;
            LOCK: err_seq_reg <= (CHECK_SEQ != 0) && (dec_idx != exp_idx_reg);
            default: state_reg <= HUNT;
          endcase
        end
      end
    end
  end

  assign bus.code_ready  = ~full;
  assign bus.index_valid = ~empty;
  assign bus.index_out   = empty ? last_out_reg : mem[rd_ptr_reg[AW-1:0]];

  assign OV         = ov_reg;
  assign err_onehot = err_onehot_reg;
  assign err_seq    = err_seq_reg;
  assign locked     = (state_reg == LOCK);
  assign err_count  = err_count_reg;

endmodule
